// File: rtl/poly_cmd_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// poly_cmd_scheduler_pkg
// Shared definitions for the polynomial accelerator command sequencer:
//   - command word layout (field offsets/widths)
//   - opcode encoding
//   - response status codes
//   - sequencer state encoding
// ---------------------------------------------------------------------------
package poly_cmd_scheduler_pkg;

  // Command word layout: [15:14] op, [13:11] slot, [10:6] degree+1, [5:0] reserved
  localparam int CMD_W      = 16;
  localparam int CMD_OP_LSB = 14;
  localparam int OP_W       = 2;
  localparam int CMD_A_LSB  = 11;
  localparam int CMD_N_LSB  = 6;
  localparam int N_W        = 5;

  localparam int STATUS_W   = 5;
  localparam int RESULT_W   = 32;

  typedef enum logic [OP_W-1:0] {
    OP_STP = 2'b00,
    OP_EVP = 2'b01,
    OP_CLR = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  // Scheduler-generated status codes; anything above ST_TIMEOUT comes from an engine
  localparam logic [STATUS_W-1:0] ST_OK      = 5'd0;
  localparam logic [STATUS_W-1:0] ST_ILLEGAL = 5'd1;
  localparam logic [STATUS_W-1:0] ST_EMPTY   = 5'd2;
  localparam logic [STATUS_W-1:0] ST_ZERO_N  = 5'd3;
  localparam logic [STATUS_W-1:0] ST_TIMEOUT = 5'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_RUN_STP = 3'd2,
    S_RUN_EVP = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  function automatic op_e cmd_op(input logic [CMD_W-1:0] cmd);
    return op_e'(cmd[CMD_OP_LSB +: OP_W]);
  endfunction

  function automatic logic [N_W-1:0] cmd_n(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_N_LSB +: N_W];
  endfunction

endpackage

// File: rtl/poly_cmd_scheduler_slot_table.sv
// ---------------------------------------------------------------------------
// poly_slot_table
// Per-slot bookkeeping: one valid bit and one stored degree+1 (N) per slot.
// Ports:
//   clk, rst         clock, asynchronous active-low reset (clears every slot)
//   wr_en/wr_addr/wr_n   mark slot valid and store its N
//   clr_en/clr_addr      invalidate a slot (stored N left as is, it is unreachable)
//   rd_addr -> rd_valid, rd_n   combinational read
// ---------------------------------------------------------------------------
module poly_slot_table #(
  parameter int NSLOT = 8,
  parameter int NW    = 5,
  localparam int AW   = $clog2(NSLOT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [NW-1:0] wr_n,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [NW-1:0] rd_n
);

  logic          valid_reg [NSLOT];
  logic [NW-1:0] n_reg     [NSLOT];

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_reg[gi] <= 1'b0;
          n_reg[gi]     <= '0;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          // A store always wins; re-storing a valid slot simply overwrites it
          valid_reg[gi] <= 1'b1;
          n_reg[gi]     <= wr_n;
        end else if (clr_en && (clr_addr == AW'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign rd_valid = valid_reg[rd_addr];
  assign rd_n     = n_reg[rd_addr];

endmodule

// File: rtl/poly_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// poly_cmd_scheduler
// Command sequencer for the polynomial evaluation accelerator. Accepts one
// command at a time, decodes it, launches the store (STP) or evaluate (EVP)
// engine, steers the shared data-FIFO pop to the running engine, watches the
// engine with a watchdog, and returns one {result,status} response.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   cmd_valid/cmd_data/cmd_ready   command handshake (ready only when idle)
//   start_stp/start_evp/abort   one-cycle engine control pulses
//   A, N                        registered slot address and degree+1 to engines
//   rd_req_stp/rd_req_evp -> en_rd_data   data-FIFO pop mux
//   done_*/status_*/result_evp  engine completion inputs
//   rsp_valid/rsp_ready/result/status     response handshake
// ---------------------------------------------------------------------------
module poly_cmd_scheduler
  import poly_cmd_scheduler_pkg::*;
#(
  parameter int NSLOT   = 8,
  parameter int TIMEOUT = 1024,
  localparam int AW     = $clog2(NSLOT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [CMD_W-1:0]    cmd_data,
  output logic                cmd_ready,
  output logic                start_stp,
  output logic                start_evp,
  output logic                abort,
  output logic [AW-1:0]       A,
  output logic [N_W-1:0]      N,
  input  logic                rd_req_stp,
  input  logic                rd_req_evp,
  output logic                en_rd_data,
  input  logic                done_stp,
  input  logic                done_evp,
  input  logic [STATUS_W-1:0] status_stp,
  input  logic [RESULT_W-1:0] result_evp,
  input  logic [STATUS_W-1:0] status_evp,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RESULT_W-1:0] result,
  output logic [STATUS_W-1:0] status
);

  localparam int             WDW    = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);

  state_e                state_reg, state_next;
  op_e                   op_reg, op_next;
  logic [AW-1:0]         slot_reg, slot_next;     // slot field of the latched command
  logic [N_W-1:0]        deg_reg, deg_next;       // N field of the latched command
  logic [AW-1:0]         a_reg, a_next;
  logic [N_W-1:0]        n_reg, n_next;
  logic [WDW-1:0]        wd_reg, wd_next;
  logic [RESULT_W-1:0]   result_reg, result_next;
  logic [STATUS_W-1:0]   status_reg, status_next;
  logic                  start_stp_reg, start_stp_next;
  logic                  start_evp_reg, start_evp_next;
  logic                  abort_reg, abort_next;

  logic                  tbl_wr_en, tbl_clr_en, tbl_rd_valid;
  logic [N_W-1:0]        tbl_rd_n;

  // Reserved command bits carry no meaning
  logic                  unused_rsvd;
  assign unused_rsvd = ^cmd_data[CMD_N_LSB-1:0];

  poly_slot_table #(
    .NSLOT (NSLOT),
    .NW    (N_W)
  ) u_slot_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (tbl_wr_en),
    .wr_addr  (a_reg),
    .wr_n     (n_reg),
    .clr_en   (tbl_clr_en),
    .clr_addr (slot_reg),
    .rd_addr  (slot_reg),
    .rd_valid (tbl_rd_valid),
    .rd_n     (tbl_rd_n)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      op_reg        <= OP_STP;
      slot_reg      <= '0;
      deg_reg       <= '0;
      a_reg         <= '0;
      n_reg         <= '0;
      wd_reg        <= '0;
      result_reg    <= '0;
      status_reg    <= '0;
      start_stp_reg <= 1'b0;
      start_evp_reg <= 1'b0;
      abort_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      slot_reg      <= slot_next;
      deg_reg       <= deg_next;
      a_reg         <= a_next;
      n_reg         <= n_next;
      wd_reg        <= wd_next;
      result_reg    <= result_next;
      status_reg    <= status_next;
      start_stp_reg <= start_stp_next;
      start_evp_reg <= start_evp_next;
      abort_reg     <= abort_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    slot_next      = slot_reg;
    deg_next       = deg_reg;
    a_next         = a_reg;
    n_next         = n_reg;
    wd_next        = wd_reg;
    result_next    = result_reg;
    status_next    = status_reg;
    start_stp_next = 1'b0;
    start_evp_next = 1'b0;
    abort_next     = 1'b0;
    tbl_wr_en      = 1'b0;
    tbl_clr_en     = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          op_next    = cmd_op(cmd_data);
          slot_next  = cmd_data[CMD_A_LSB +: AW];
          deg_next   = cmd_n(cmd_data);
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        result_next = '0;
        wd_next     = '0;
        unique case (op_reg)
          OP_STP: begin
            if (deg_reg == '0) begin
              status_next = ST_ZERO_N;
              state_next  = S_RESP;
            end else begin
              a_next         = slot_reg;
              n_next         = deg_reg;
              start_stp_next = 1'b1;
              state_next     = S_RUN_STP;
            end
          end
          OP_EVP: begin
            if (!tbl_rd_valid) begin
              status_next = ST_EMPTY;
              state_next  = S_RESP;
            end else begin
              // Evaluation uses the degree recorded when the slot was stored
              a_next         = slot_reg;
              n_next         = tbl_rd_n;
              start_evp_next = 1'b1;
              state_next     = S_RUN_EVP;
            end
          end
          OP_CLR: begin
            tbl_clr_en  = 1'b1;
            status_next = ST_OK;
            state_next  = S_RESP;
          end
          default: begin
            status_next = ST_ILLEGAL;
            state_next  = S_RESP;
          end
        endcase
      end

      S_RUN_STP: begin
        // done is checked before the watchdog so a last-cycle done still completes
        if (done_stp) begin
          tbl_wr_en   = (status_stp == ST_OK);
          status_next = status_stp;
          result_next = '0;
          state_next  = S_RESP;
        end else if (wd_reg == WD_MAX) begin
          abort_next  = 1'b1;
          status_next = ST_TIMEOUT;
          result_next = '0;
          state_next  = S_RESP;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end

      S_RUN_EVP: begin
        if (done_evp) begin
          status_next = status_evp;
          result_next = result_evp;
          state_next  = S_RESP;
        end else if (wd_reg == WD_MAX) begin
          abort_next  = 1'b1;
          status_next = ST_TIMEOUT;
          result_next = '0;
          state_next  = S_RESP;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign cmd_ready  = (state_reg == S_IDLE);
  assign rsp_valid  = (state_reg == S_RESP);
  assign en_rd_data = ((state_reg == S_RUN_STP) && rd_req_stp) ||
                      ((state_reg == S_RUN_EVP) && rd_req_evp);
  assign start_stp  = start_stp_reg;
  assign start_evp  = start_evp_reg;
  assign abort      = abort_reg;
  assign A          = a_reg;
  assign N          = n_reg;
  assign result     = result_reg;
  assign status     = status_reg;

endmodule
